// File: rtl/bwt_pkg.sv
// Shared types for the BWT sort controller: row element, FSM state encoding and error bit positions.
package bwt_pkg;

    localparam int ELEMENT_LEN = 8;
    localparam int ERR_LEN     = 0;
    localparam int ERR_TMO     = 1;

    typedef logic [ELEMENT_LEN-1:0] elem_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BUILD,
        ST_START,
        ST_WAIT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_EMIT
    } bwt_ctrl_state_t;

endpackage

// File: rtl/bwt_emit_stream.sv
// Output stage: streams the captured BWT column one registered row per valid/ready handshake.
module bwt_emit_stream
    import bwt_pkg::*;
#(
    parameter  int ROWS  = 8,
    localparam int IDX_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_i,
    input  elem_t            col_i [0:ROWS-1],
    input  logic             m_ready_i,
    output logic             m_valid_o,
    output elem_t            m_data_o,
    output logic [IDX_W-1:0] m_index_o,
    output logic             m_last_o,
    output logic             done_o
);

    logic             valid_q, valid_d;
    elem_t            data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_nxt;
    logic             last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        idx_nxt = idx_q + 1'b1;
        done_o  = valid_q && m_ready_i && last_q;

        if (go_i) begin
            valid_d = 1'b1;
            idx_d   = '0;
            data_d  = col_i[0];
            last_d  = (ROWS == 1);
        end else if (valid_q && m_ready_i) begin
            if (last_q) begin
                valid_d = 1'b0;
                idx_d   = '0;
                data_d  = '0;
                last_d  = 1'b0;
            end else begin
                idx_d  = idx_nxt;
                data_d = col_i[idx_nxt];
                last_d = (idx_nxt == IDX_W'(ROWS-1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;
    assign m_index_o = idx_q;
    assign m_last_o  = last_q;

endmodule

// File: rtl/bwt_sort_ctrl.sv
// Sequences one merge-sort job per input string: load, build rotation keys, launch, wait, capture, emit BWT column.
//
// state   | meaning
// IDLE    | ready for the first byte of a string
// LOAD    | collecting bytes 1..STRING_LEN-1
// BUILD   | registering the rotation key matrix
// START   | one-cycle launch pulse to the sort network
// WAIT    | waiting for sorted, bounded by TIMEOUT
// SETTLE  | one cycle for the network to commit its last row
// CAPTURE | registering the sorted BWT column
// EMIT    | streaming rows downstream
module bwt_sort_ctrl
    import bwt_pkg::*;
#(
    parameter  int STRING_LEN = 8,
    parameter  int COLUMN     = 3,
    parameter  int TIMEOUT    = 255,
    localparam int IDX_W      = $clog2(STRING_LEN),
    localparam int TMO_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [ELEMENT_LEN-1:0] s_data,
    input  logic                   s_last,
    input  logic [1:0]             cfg_sort_num,
    output logic                   sort_start,
    output logic [1:0]             sort_num,
    output logic [ELEMENT_LEN-1:0] sort_data [0:STRING_LEN-1][COLUMN-1:0],
    input  logic                   sort_sorted,
    input  logic [ELEMENT_LEN-1:0] sort_result [0:STRING_LEN-1][COLUMN-1:0],
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ELEMENT_LEN-1:0] m_data,
    output logic [IDX_W-1:0]       m_index,
    output logic                   m_last,
    output logic                   busy,
    output logic [1:0]             err,
    input  logic                   err_clr
);

    bwt_ctrl_state_t  state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       err_q, err_d;
    logic [1:0]       num_q, num_d;
    logic             s_ready_q, s_ready_d;
    logic             start_q, start_d;
    logic             go_q, go_d;
    logic             accept;
    logic             str_we;
    logic [IDX_W-1:0] str_wa;
    logic             emit_done;
    logic             unused_keys;

    elem_t str_q       [0:STRING_LEN-1];
    elem_t res_q       [0:STRING_LEN-1];
    elem_t sort_data_q [0:STRING_LEN-1][COLUMN-1:0];

    assign accept = s_valid && s_ready_q;
    assign str_wa = (state_q == ST_IDLE) ? '0 : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        num_d   = num_q;
        str_we  = 1'b0;
        go_d    = 1'b0;

        // Clear first so that an error raised in the same cycle still sticks.
        if (err_clr) err_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    str_we = 1'b1;
                    num_d  = cfg_sort_num;
                    cnt_d  = IDX_W'(1);
                    if (s_last) err_d[ERR_LEN] = 1'b1;
                    else        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    str_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(STRING_LEN-1)) begin
                        state_d = ST_BUILD;
                        if (!s_last) err_d[ERR_LEN] = 1'b1;
                    end else if (s_last) begin
                        err_d[ERR_LEN] = 1'b1;
                        state_d        = ST_IDLE;
                    end
                end
            end
            ST_BUILD: state_d = ST_START;
            ST_START: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                if (sort_sorted) begin
                    state_d = ST_SETTLE;
                end else if (tmo_q == TMO_W'(TIMEOUT-1)) begin
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_SETTLE:  state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                state_d = ST_EMIT;
                go_d    = 1'b1;
            end
            ST_EMIT: if (emit_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        start_d   = (state_d == ST_START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            err_q     <= '0;
            num_q     <= '0;
            s_ready_q <= 1'b0;
            start_q   <= 1'b0;
            go_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            num_q     <= num_d;
            s_ready_q <= s_ready_d;
            start_q   <= start_d;
            go_q      <= go_d;
        end
    end

    // Row r is rotation r of the string; the last column holds the byte preceding that rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < STRING_LEN; r++) begin
                str_q[r] <= '0;
                res_q[r] <= '0;
                for (int c = 0; c < COLUMN; c++) sort_data_q[r][c] <= '0;
            end
        end else begin
            if (str_we) str_q[str_wa] <= s_data;
            if (state_q == ST_BUILD) begin
                for (int r = 0; r < STRING_LEN; r++) begin
                    for (int c = 0; c < COLUMN-1; c++)
                        sort_data_q[r][c] <= str_q[IDX_W'(r + c)];
                    sort_data_q[r][COLUMN-1] <= str_q[IDX_W'(r - 1)];
                end
            end
            if (state_q == ST_CAPTURE) begin
                for (int r = 0; r < STRING_LEN; r++) res_q[r] <= sort_result[r][COLUMN-1];
            end
        end
    end

    // Key prefix columns of the sorted matrix are not needed downstream.
    always_comb begin
        unused_keys = 1'b0;
        for (int r = 0; r < STRING_LEN; r++)
            for (int c = 0; c < COLUMN-1; c++)
                unused_keys = unused_keys ^ (^sort_result[r][c]);
    end

    bwt_emit_stream #(
        .ROWS (STRING_LEN)
    ) u_emit (
        .clk       (clk),
        .rst       (rst),
        .go_i      (go_q),
        .col_i     (res_q),
        .m_ready_i (m_ready),
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .m_index_o (m_index),
        .m_last_o  (m_last),
        .done_o    (emit_done)
    );

    assign s_ready    = s_ready_q;
    assign sort_start = start_q;
    assign sort_num   = num_q;
    assign sort_data  = sort_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;

endmodule
